// File: rtl/mc_controller.sv
// mc_controller
//   Control unit for a multicycle MIPS datapath: a main-decoder FSM that
//   sequences each instruction through fetch/decode/execute/writeback, plus
//   an ALU decoder that turns the FSM's ALU operation class (and the funct
//   field for R-type) into the 3-bit alucontrol code.
//
//   Memory accesses (instruction fetch, load read, store write) stall on
//   mem_ready: the FSM holds its state until memory reports completion.
//
//   Optional feature (compile-time macro MC_CTRL_BNE_EN):
//     defined   -> op 000101 (bne) runs through a BNEEX state that branches
//                  when the ALU zero flag is clear.
//     undefined -> op 000101 is unknown and executes as a NOP.
//
// Parameters
//   OPW  opcode field width
//   FW   funct field width
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high; forces FETCH
//   op          in   opcode from instruction register
//   funct       in   funct from instruction register
//   zero        in   ALU zero flag
//   mem_ready   in   memory completes the current access this cycle
//   pcen        out  PC register enable
//   memwrite    out  data memory write strobe
//   irwrite     out  instruction register enable
//   regwrite    out  register file write enable
//   iord        out  memory address select (0=PC, 1=ALUOut)
//   memtoreg    out  writeback source (0=ALUOut, 1=memory data)
//   regdst      out  destination register (0=rt, 1=rd)
//   alusrca     out  ALU A operand (0=PC, 1=A)
//   alusrcb     out  ALU B operand (00=B, 01=4, 10=SignImm, 11=SignImm<<2)
//   pcsrc       out  PC source (00=ALUResult, 01=ALUOut, 10=PCJump)
//   alucontrol  out  ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
module mc_controller #(
  parameter int OPW = 6,
  parameter int FW  = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [FW-1:0]  funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pcen,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regwrite,
  output logic           iord,
  output logic           memtoreg,
  output logic           regdst,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [2:0]     alucontrol
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_FN  = 2'b10
  } aluop_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  // ALU decoder. Unknown funct codes fall back to add so the R-type
  // writeback still produces a defined value.
  function automatic logic [2:0] alu_dec(input aluop_t aop, input logic [FW-1:0] fn);
    logic [2:0] r;
    r = 3'b010;
    case (aop)
      ALUOP_ADD: r = 3'b010;
      ALUOP_SUB: r = 3'b110;
      ALUOP_FN: begin
        case (fn)
          FW'(6'b100000): r = 3'b010;
          FW'(6'b100010): r = 3'b110;
          FW'(6'b100100): r = 3'b000;
          FW'(6'b100101): r = 3'b001;
          FW'(6'b101010): r = 3'b111;
          default:        r = 3'b010;
        endcase
      end
      default: r = 3'b010;
    endcase
    return r;
  endfunction

  state_t state, state_nx;
  aluop_t aluop;
  logic   pcen_raw, memwrite_raw, irwrite_raw, regwrite_raw;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    pcen_raw     = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        // PC+4 is computed every cycle but only committed with the fetch.
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcen_raw    = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while decoding.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_RTYPEEX;
          OP_BEQ:       state_nx = S_BEQEX;
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JEX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_nx = S_BNEEX;
`endif
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      state_nx = S_MEMRD;
        else if (op == OP_SW) state_nx = S_MEMWR;
        else                  state_nx = S_FETCH;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
        state_nx     = S_FETCH;
      end
      S_MEMWR: begin
        // Strobe held for the whole access, not just the completing cycle.
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_FN;
        state_nx = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        state_nx     = S_FETCH;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = 2'b01;
        pcen_raw = zero;
        state_nx = S_FETCH;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNEEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = 2'b01;
        pcen_raw = ~zero;
        state_nx = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        state_nx = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        state_nx     = S_FETCH;
      end
      S_JEX: begin
        pcsrc    = 2'b10;
        pcen_raw = 1'b1;
        state_nx = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // Architectural state must not change while reset is held, even when the
  // FSM is still sitting in a state that would otherwise write.
  assign pcen       = pcen_raw     & ~reset;
  assign memwrite   = memwrite_raw & ~reset;
  assign irwrite    = irwrite_raw  & ~reset;
  assign regwrite   = regwrite_raw & ~reset;
  assign alucontrol = alu_dec(aluop, funct);

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
//   Scoreboard bench for mc_controller. The driver applies one cycle of
//   inputs at a time and pushes the hand-written expected output vector for
//   that cycle; the monitor pops and compares on the falling edge.
//   Output vector bit order:
//   {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,
//    alusrcb[1:0],pcsrc[1:0],alucontrol[2:0]}
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  mc_controller #(.OPW(6), .FW(6)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  logic [14:0] act;
  assign act = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                alusrca, alusrcb, pcsrc, alucontrol};

  //                              pmir imra b  pc alu
  localparam logic [14:0] E_FWAIT  = 15'b0000_0000_01_00_010;
  localparam logic [14:0] E_FRDY   = 15'b1010_0000_01_00_010;
  localparam logic [14:0] E_DEC    = 15'b0000_0000_11_00_010;
  localparam logic [14:0] E_MADR   = 15'b0000_0001_10_00_010;
  localparam logic [14:0] E_MRD    = 15'b0000_1000_00_00_010;
  localparam logic [14:0] E_MWB    = 15'b0001_0100_00_00_010;
  localparam logic [14:0] E_MWR    = 15'b0100_1000_00_00_010;
  localparam logic [14:0] E_RWB    = 15'b0001_0010_00_00_010;
  localparam logic [14:0] E_BEQ1   = 15'b1000_0001_00_01_110;
  localparam logic [14:0] E_BEQ0   = 15'b0000_0001_00_01_110;
  localparam logic [14:0] E_AEX    = 15'b0000_0001_10_00_010;
  localparam logic [14:0] E_AWB    = 15'b0001_0000_00_00_010;
  localparam logic [14:0] E_JEX    = 15'b1000_0000_00_10_010;
  localparam logic [12:0] E_REX_HI = 13'b0000_0001_00_00;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_BAD = 6'b111111;

  typedef struct {
    logic [14:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic done = 1'b0;

  task automatic cyc(input string name, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic mr, input logic rst,
                     input logic [14:0] e);
    exp_t x;
    op = o; funct = f; zero = z; mem_ready = mr; reset = rst;
    x.v = e;
    x.name = name;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
  logic [2:0] alu_tab [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

  // Driver
  initial begin
    reset = 1'b1; mem_ready = 1'b0; op = '0; funct = '0; zero = 1'b0;
    @(posedge clk);
    #1;
    // Reset and idle fetch
    cyc("rst_fetch0", OP_R, 6'd0, 0, 0, 1, E_FWAIT);
    cyc("rst_fetch1", OP_R, 6'd0, 0, 0, 1, E_FWAIT);
    cyc("rst_rdy_gated", OP_R, 6'd0, 0, 1, 1, E_FWAIT);
    for (int i = 0; i < 3; i++) cyc("fetch_stall", OP_R, 6'd0, 0, 0, 0, E_FWAIT);
    // lw, no stalls
    cyc("lw_fetch", OP_LW, 6'd0, 0, 1, 0, E_FRDY);
    cyc("lw_dec",   OP_LW, 6'd0, 0, 1, 0, E_DEC);
    cyc("lw_madr",  OP_LW, 6'd0, 0, 1, 0, E_MADR);
    cyc("lw_mrd",   OP_LW, 6'd0, 0, 1, 0, E_MRD);
    cyc("lw_mwb",   OP_LW, 6'd0, 0, 1, 0, E_MWB);
    // sw with two wait cycles
    cyc("sw_fetch", OP_SW, 6'd0, 0, 1, 0, E_FRDY);
    cyc("sw_dec",   OP_SW, 6'd0, 0, 1, 0, E_DEC);
    cyc("sw_madr",  OP_SW, 6'd0, 0, 1, 0, E_MADR);
    cyc("sw_wait0", OP_SW, 6'd0, 0, 0, 0, E_MWR);
    cyc("sw_wait1", OP_SW, 6'd0, 0, 0, 0, E_MWR);
    cyc("sw_done",  OP_SW, 6'd0, 0, 1, 0, E_MWR);
    // R-type across all funct codes plus an unknown one
    for (int i = 0; i < 6; i++) begin
      cyc("r_fetch", OP_R, fn_tab[i], 0, 1, 0, E_FRDY);
      cyc("r_dec",   OP_R, fn_tab[i], 0, 1, 0, E_DEC);
      cyc("r_ex",    OP_R, fn_tab[i], 0, 1, 0, {E_REX_HI, alu_tab[i]});
      cyc("r_wb",    OP_R, fn_tab[i], 0, 1, 0, E_RWB);
    end
    // beq taken / not taken
    cyc("beq1_fetch", OP_BEQ, 6'd0, 1, 1, 0, E_FRDY);
    cyc("beq1_dec",   OP_BEQ, 6'd0, 1, 1, 0, E_DEC);
    cyc("beq1_ex",    OP_BEQ, 6'd0, 1, 1, 0, E_BEQ1);
    cyc("beq0_fetch", OP_BEQ, 6'd0, 0, 1, 0, E_FRDY);
    cyc("beq0_dec",   OP_BEQ, 6'd0, 0, 1, 0, E_DEC);
    cyc("beq0_ex",    OP_BEQ, 6'd0, 0, 1, 0, E_BEQ0);
    // addi
    cyc("addi_fetch", OP_ADDI, 6'd0, 0, 1, 0, E_FRDY);
    cyc("addi_dec",   OP_ADDI, 6'd0, 0, 1, 0, E_DEC);
    cyc("addi_ex",    OP_ADDI, 6'd0, 0, 1, 0, E_AEX);
    cyc("addi_wb",    OP_ADDI, 6'd0, 0, 1, 0, E_AWB);
    // j
    cyc("j_fetch", OP_J, 6'd0, 0, 1, 0, E_FRDY);
    cyc("j_dec",   OP_J, 6'd0, 0, 1, 0, E_DEC);
    cyc("j_ex",    OP_J, 6'd0, 0, 1, 0, E_JEX);
    // reset in MEMRD after a read stall
    cyc("lwr_fetch", OP_LW, 6'd0, 0, 1, 0, E_FRDY);
    cyc("lwr_dec",   OP_LW, 6'd0, 0, 1, 0, E_DEC);
    cyc("lwr_madr",  OP_LW, 6'd0, 0, 1, 0, E_MADR);
    cyc("lwr_stall", OP_LW, 6'd0, 0, 0, 0, E_MRD);
    cyc("lwr_rst",   OP_LW, 6'd0, 0, 1, 1, E_MRD);
    cyc("lwr_after", OP_LW, 6'd0, 0, 0, 0, E_FWAIT);
    // unknown op executes as NOP
    cyc("bad_fetch", OP_BAD, 6'd0, 0, 1, 0, E_FRDY);
    cyc("bad_dec",   OP_BAD, 6'd0, 0, 1, 0, E_DEC);
    cyc("bad_after", OP_BAD, 6'd0, 0, 0, 0, E_FWAIT);
    // bne with zero=0
    cyc("bne_fetch", OP_BNE, 6'd0, 0, 1, 0, E_FRDY);
    cyc("bne_dec",   OP_BNE, 6'd0, 0, 1, 0, E_DEC);
`ifdef MC_CTRL_BNE_EN
    cyc("bne_ex",    OP_BNE, 6'd0, 0, 0, 0, E_BEQ1);
    cyc("bne_after", OP_BNE, 6'd0, 0, 0, 0, E_FWAIT);
`else
    cyc("bne_nop",   OP_BNE, 6'd0, 0, 0, 0, E_FWAIT);
    cyc("bne_fetch2", OP_BNE, 6'd0, 0, 1, 0, E_FRDY);
`endif
    done = 1'b1;
  end

  // Monitor
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (done) break;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        tests++;
        if (act !== x.v) begin
          fails++;
          $display("FAIL %s: got %b expected %b", x.name, act, x.v);
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
